// File: rtl/pmod_als_pkg.sv
// Shared types and frame geometry for the PmodALS (ADC081S021) SPI master.
package pmod_als_pkg;

  localparam int unsigned ALS_FRAME_BITS = 16;
  localparam int unsigned ALS_DATA_MSB   = 12;
  localparam int unsigned ALS_DATA_LSB   = 5;
  localparam int unsigned ALS_DATA_W     = ALS_DATA_MSB - ALS_DATA_LSB + 1;
  localparam int unsigned ALS_BITCNT_W   = $clog2(ALS_FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } als_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider for scl: tick every CLK_DIV enabled clocks, plus rise strobe.
module spi_clk_div
  import pmod_als_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic scl,
  output logic tick_c,
  output logic rise_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && (cnt == CNT_W'(CLK_DIV - 1));
  // A tick while scl is low is the 0->1 transition.
  assign rise_c = tick_c && !scl;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pmod_als_spi_master.sv
// SPI master for the PmodALS light sensor; one 8-bit sample per 16-bit frame.
// Optional PMODALS_FRAME_CHECK_EN adds frame_err for non-zero pad bits.
module pmod_als_spi_master
  import pmod_als_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned GAP_CYCLES = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sdo,
  output logic                  cs,
  output logic                  scl,
  output logic [ALS_DATA_W-1:0] data,
  output logic                  valid,
  output logic                  busy
`ifdef PMODALS_FRAME_CHECK_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  als_state_e                state, state_d;
  logic                      cs_d, scl_d, busy_d, valid_d;
  logic [ALS_DATA_W-1:0]     data_d;
  logic [ALS_FRAME_BITS-1:0] shreg, shreg_d;
  logic [ALS_BITCNT_W-1:0]   bitcnt, bitcnt_d;
  logic [GAP_W-1:0]          gcnt, gcnt_d;
  logic                      tick_c, rise_c;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .en     ((state == SETUP) || (state == SHIFT)),
    .scl    (scl),
    .tick_c (tick_c),
    .rise_c (rise_c)
  );

`ifdef PMODALS_FRAME_CHECK_EN
  logic frame_err_d;
`else
  logic unused_c;
  assign unused_c = ^{shreg[ALS_FRAME_BITS-1:ALS_DATA_MSB+1], shreg[ALS_DATA_LSB-1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cs        <= 1'b1;
      scl       <= 1'b1;
      busy      <= 1'b0;
      valid     <= 1'b0;
      data      <= '0;
      shreg     <= '0;
      bitcnt    <= '0;
      gcnt      <= '0;
`ifdef PMODALS_FRAME_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cs        <= cs_d;
      scl       <= scl_d;
      busy      <= busy_d;
      valid     <= valid_d;
      data      <= data_d;
      shreg     <= shreg_d;
      bitcnt    <= bitcnt_d;
      gcnt      <= gcnt_d;
`ifdef PMODALS_FRAME_CHECK_EN
      frame_err <= frame_err_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    cs_d        = cs;
    scl_d       = scl;
    busy_d      = busy;
    valid_d     = 1'b0;
    data_d      = data;
    shreg_d     = shreg;
    bitcnt_d    = bitcnt;
    gcnt_d      = gcnt;
`ifdef PMODALS_FRAME_CHECK_EN
    frame_err_d = frame_err;
`endif
    case (state)
      IDLE: begin
        cs_d   = 1'b1;
        scl_d  = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d  = SETUP;
          cs_d     = 1'b0;
          busy_d   = 1'b1;
          bitcnt_d = '0;
        end
      end
      SETUP: begin
        if (tick_c) begin
          scl_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (rise_c) begin
          scl_d    = 1'b1;
          shreg_d  = {shreg[ALS_FRAME_BITS-2:0], sdo};
          bitcnt_d = bitcnt + ALS_BITCNT_W'(1);
        end else if (tick_c && (bitcnt == '0)) begin
          // Counter wrapped on the 16th rise: end of frame, no trailing fall.
          cs_d    = 1'b1;
          data_d  = shreg[ALS_DATA_MSB:ALS_DATA_LSB];
          valid_d = 1'b1;
          gcnt_d  = '0;
          state_d = GAP;
`ifdef PMODALS_FRAME_CHECK_EN
          frame_err_d = (shreg[ALS_FRAME_BITS-1:ALS_DATA_MSB+1] != '0) ||
                        (shreg[ALS_DATA_LSB-1:0] != '0);
`endif
        end else if (tick_c) begin
          scl_d = 1'b0;
        end
      end
      GAP: begin
        cs_d  = 1'b1;
        scl_d = 1'b1;
        if (gcnt == GAP_W'(GAP_CYCLES - 1)) begin
          if (start) begin
            state_d  = SETUP;
            cs_d     = 1'b0;
            bitcnt_d = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gcnt_d = gcnt + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pmod_als_spi_master.sv
// Self-checking bench for pmod_als_spi_master: two instances (D=2/G=8 and D=1/G=1).
module tb_pmod_als_spi_master;

  localparam int DA = 2;
  localparam int GA = 8;
  localparam int DB = 1;
  localparam int GB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic [15:0] word_a = 16'h0, word_b = 16'h0;
  int rises_a = 0, rises_b = 0;
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;

  logic sdo_a, cs_a, scl_a, valid_a, busy_a;
  logic sdo_b, cs_b, scl_b, valid_b, busy_b;
  logic [7:0] data_a, data_b;
  logic cs_m, scl_m, valid_m, busy_m;
  logic [7:0] data_m;
`ifdef PMODALS_FRAME_CHECK_EN
  logic frame_err_a, frame_err_b, frame_err_m;
  assign frame_err_m = sel ? frame_err_b : frame_err_a;
`endif

  pmod_als_spi_master #(.CLK_DIV(DA), .GAP_CYCLES(GA)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .sdo(sdo_a), .cs(cs_a), .scl(scl_a),
    .data(data_a), .valid(valid_a), .busy(busy_a)
`ifdef PMODALS_FRAME_CHECK_EN
    , .frame_err(frame_err_a)
`endif
  );

  pmod_als_spi_master #(.CLK_DIV(DB), .GAP_CYCLES(GB)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .sdo(sdo_b), .cs(cs_b), .scl(scl_b),
    .data(data_b), .valid(valid_b), .busy(busy_b)
`ifdef PMODALS_FRAME_CHECK_EN
    , .frame_err(frame_err_b)
`endif
  );

  assign cs_m    = sel ? cs_b    : cs_a;
  assign scl_m   = sel ? scl_b   : scl_a;
  assign valid_m = sel ? valid_b : valid_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign data_m  = sel ? data_b  : data_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor model: n-th bit (MSB first) is presented before the n-th scl rise.
  function automatic logic sensor_bit(input logic [15:0] w, input int n);
    logic [15:0] t;
    t = w;
    if (n < 0 || n > 15) return 1'b0;
    return t[15 - n];
  endfunction

  always @(negedge cs_a) rises_a = 0;
  always @(posedge scl_a) if (cs_a === 1'b0) rises_a = rises_a + 1;
  always @(negedge cs_b) rises_b = 0;
  always @(posedge scl_b) if (cs_b === 1'b0) rises_b = rises_b + 1;
  assign sdo_a = sensor_bit(word_a, rises_a);
  assign sdo_b = sensor_bit(word_b, rises_b);

  // Reference: sample is the 8 bits after the 3 leading zeros; pads must be zero.
  function automatic logic [7:0] ref_sample(input logic [15:0] w);
    return 8'((int'(w) / 32) % 256);
  endfunction

  function automatic logic ref_err(input logic [15:0] w);
    return ((int'(w) / 8192) != 0) || ((int'(w) % 32) != 0);
  endfunction

  function automatic logic [15:0] rand_word();
    logic [7:0] s;
    s = 8'($urandom_range(0, 255));
    return 16'(int'(s) * 32);
  endfunction

  // Runs one frame from an idle DUT and measures it; returns at the valid sample.
  task automatic do_frame(input logic [15:0] w, input int d, output int lat, output int rises,
                          output int cslow, output logic [7:0] dat, output bit got);
    bit prev_scl;
    int e0;
    if (sel) word_b = w; else word_a = w;
    lat = -1; rises = 0; cslow = 0; dat = 8'h00; got = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
    prev_scl = 1'b1;
    for (int i = 0; i < 33 * d + 20 && !got; i++) begin
      if (!cs_m) cslow++;
      if (!cs_m && scl_m && !prev_scl) rises++;
      prev_scl = scl_m;
      if (valid_m) begin
        got = 1'b1; lat = cyc - e0; dat = data_m;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy_m) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if ({cs_a, scl_a, valid_a, busy_a, data_a} !== {4'b1100, 8'h00}) begin
        n_bad++; $display("FAIL reset_a[%0d]: cs/scl/valid/busy/data got %b%b%b%b %h want 1100 00", i, cs_a, scl_a, valid_a, busy_a, data_a);
      end
      n_cmp++; if ({cs_b, scl_b, valid_b, busy_b, data_b} !== {4'b1100, 8'h00}) begin
        n_bad++; $display("FAIL reset_b[%0d]: cs/scl/valid/busy/data got %b%b%b%b %h want 1100 00", i, cs_b, scl_b, valid_b, busy_b, data_b);
      end
    end
`ifdef PMODALS_FRAME_CHECK_EN
    n_cmp++; if (frame_err_a !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err_a); end
`endif
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bit prev_scl, ok;
    int rises, nval;
    int lat, cl; logic [7:0] dat; bit got;
    sel = 1'b0; word_a = rand_word();
    start = 1'b1; @(negedge clk); start = 1'b0;
    prev_scl = 1'b1; rises = 0;
    for (int i = 0; i < 100 && rises < 7; i++) begin
      @(negedge clk);
      if (!cs_m && scl_m && !prev_scl) rises++;
      prev_scl = scl_m;
    end
    n_cmp++; if (rises !== 7) begin n_bad++; $display("FAIL midrst_rises: got %0d want 7", rises); end
    rst = 1'b1; @(negedge clk);
    n_cmp++; if ({cs_m, scl_m, valid_m, busy_m, data_m} !== {4'b1100, 8'h00}) begin
      n_bad++; $display("FAIL midrst_outs: cs/scl/valid/busy/data got %b%b%b%b %h want 1100 00", cs_m, scl_m, valid_m, busy_m, data_m);
    end
    rst = 1'b0; nval = 0;
    for (int i = 0; i < 80; i++) begin @(negedge clk); if (valid_m) nval++; end
    n_cmp++; if (nval !== 0 || data_m !== 8'h00) begin
      n_bad++; $display("FAIL midrst_novalid: valids %0d data %h want 0 00", nval, data_m);
    end
    word_a = rand_word();
    do_frame(word_a, DA, lat, rises, cl, dat, got);
    n_cmp++; if (!got || dat !== ref_sample(word_a) || lat !== 33 * DA) begin
      n_bad++; $display("FAIL midrst_frame: got %0b data %h lat %0d want data %h lat %0d", got, dat, lat, ref_sample(word_a), 33 * DA);
    end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL midrst_idle: busy stuck, got 1 want 0"); end
  endtask

  task automatic test_single_frame();
    int lat, rises, cl; logic [7:0] dat; bit got, ok;
    sel = 1'b0;
    do_frame(16'h14A0, DA, lat, rises, cl, dat, got);
    n_cmp++; if (dat !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", dat); end
    n_cmp++; if (lat !== 33 * DA) begin n_bad++; $display("FAIL single_latency: got %0d want %0d", lat, 33 * DA); end
    n_cmp++; if (rises !== 16) begin n_bad++; $display("FAIL single_rises: got %0d want 16", rises); end
    n_cmp++; if (cl !== 33 * DA) begin n_bad++; $display("FAIL single_cslow: got %0d want %0d", cl, 33 * DA); end
    @(negedge clk);
    n_cmp++; if (valid_m !== 1'b0) begin n_bad++; $display("FAIL single_valid_pulse: got %b want 0", valid_m); end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_idle: busy stuck, got 1 want 0"); end
  endtask

  task automatic test_random_frames();
    int lat, rises, cl; logic [7:0] dat; bit got, ok;
    logic [15:0] w;
    for (int k = 0; k < 8; k++) begin
      sel = (k >= 5);
      w = rand_word();
      do_frame(w, sel ? DB : DA, lat, rises, cl, dat, got);
      n_cmp++; if (!got || dat !== ref_sample(w) || lat !== 33 * (sel ? DB : DA) || rises !== 16) begin
        n_bad++; $display("FAIL rand_frame[%0d]: w %h got %0b data %h lat %0d rises %0d want data %h lat %0d rises 16",
                          k, w, got, dat, lat, rises, ref_sample(w), 33 * (sel ? DB : DA));
      end
`ifdef PMODALS_FRAME_CHECK_EN
      n_cmp++; if (frame_err_m !== ref_err(w)) begin n_bad++; $display("FAIL rand_frame_err[%0d]: got %b want %b", k, frame_err_m, ref_err(w)); end
`endif
      wait_idle(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand_idle[%0d]: busy stuck, got 1 want 0", k); end
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    int e0, nval, nfall, fall_at, v2;
    bit prev_cs, ok;
    logic [7:0] d2;
    sel = 1'b0; word_a = rand_word();
    start = 1'b1; @(negedge clk); start = 1'b0; e0 = cyc;
    nval = 0; nfall = 0; prev_cs = 1'b0;
    for (int i = 0; i < 100; i++) begin
      start = (cyc == e0 + 9);
      @(negedge clk);
      if (valid_m) nval++;
      if (prev_cs && !cs_m) nfall++;
      prev_cs = cs_m;
    end
    start = 1'b0;
    n_cmp++; if (nval !== 1 || nfall !== 0) begin
      n_bad++; $display("FAIL busy_ignore: valids %0d extra cs falls %0d want 1 0", nval, nfall);
    end
    n_cmp++; if (data_m !== ref_sample(word_a)) begin n_bad++; $display("FAIL busy_data: got %h want %h", data_m, ref_sample(word_a)); end
    wait_idle(ok);
    word_a = rand_word();
    start = 1'b1; @(negedge clk); e0 = cyc;
    prev_cs = 1'b0; fall_at = -1; v2 = 0; d2 = 8'h00;
    for (int i = 0; i < 250 && v2 < 2; i++) begin
      @(negedge clk);
      if (valid_m) begin v2++; d2 = data_m; end
      if (prev_cs && !cs_m && fall_at < 0) begin fall_at = cyc - e0; start = 1'b0; end
      prev_cs = cs_m;
    end
    start = 1'b0;
    n_cmp++; if (fall_at !== 33 * DA + GA) begin n_bad++; $display("FAIL held_start_cs_fall: got %0d want %0d", fall_at, 33 * DA + GA); end
    n_cmp++; if (v2 !== 2 || d2 !== ref_sample(word_a)) begin
      n_bad++; $display("FAIL held_start_frames: valids %0d data %h want 2 %h", v2, d2, ref_sample(word_a));
    end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_idle: busy stuck, got 1 want 0"); end
  endtask

  task automatic test_frame_check();
    int lat, rises, cl; logic [7:0] dat; bit got, ok;
    sel = 1'b0;
    do_frame(16'h94A0, DA, lat, rises, cl, dat, got);
    n_cmp++; if (dat !== ref_sample(16'h94A0)) begin n_bad++; $display("FAIL fchk_data1: got %h want %h", dat, ref_sample(16'h94A0)); end
`ifdef PMODALS_FRAME_CHECK_EN
    n_cmp++; if (frame_err_m !== 1'b1) begin n_bad++; $display("FAIL fchk_err1: got %b want 1", frame_err_m); end
`endif
    wait_idle(ok);
`ifdef PMODALS_FRAME_CHECK_EN
    n_cmp++; if (frame_err_m !== 1'b1) begin n_bad++; $display("FAIL fchk_err_hold: got %b want 1", frame_err_m); end
`endif
    do_frame(16'h0020, DA, lat, rises, cl, dat, got);
    n_cmp++; if (dat !== 8'h01) begin n_bad++; $display("FAIL fchk_data2: got %h want 01", dat); end
`ifdef PMODALS_FRAME_CHECK_EN
    n_cmp++; if (frame_err_m !== 1'b0) begin n_bad++; $display("FAIL fchk_err2: got %b want 0", frame_err_m); end
`endif
    wait_idle(ok);
  endtask

  task automatic test_div_boundary();
    int lat, rises, cl; logic [7:0] dat; bit got, ok;
    sel = 1'b1;
    do_frame(16'h1FE0, DB, lat, rises, cl, dat, got);
    n_cmp++; if (!got || dat !== 8'hFF || lat !== 33) begin
      n_bad++; $display("FAIL div1_frame: got %0b data %h lat %0d want data ff lat 33", got, dat, lat);
    end
    n_cmp++; if (rises !== 16 || cl !== 33) begin n_bad++; $display("FAIL div1_shape: rises %0d cslow %0d want 16 33", rises, cl); end
    n_cmp++; if (busy_m !== 1'b1) begin n_bad++; $display("FAIL div1_busy_at33: got %b want 1", busy_m); end
    @(negedge clk);
    n_cmp++; if (busy_m !== 1'b0) begin n_bad++; $display("FAIL div1_busy_at34: got %b want 0", busy_m); end
    wait_idle(ok);
    sel = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got hang want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mid_reset();
    test_single_frame();
    test_random_frames();
    test_back_to_back();
    test_frame_check();
    test_div_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
